// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: drives the combinational ROM address from the fetch PC and queues {pc, word} pairs for decode.
// Latency: a word is pushed on the edge it is addressed and is presented to decode on the following cycle; redirect target is visible 2 cycles after the redirect edge.
// Backpressure: instr_ready low fills the DEPTH-entry queue, then fetch_pc/imem_addr hold until a pop frees a slot. Optional FETCH_HALT_EN adds a halted output and stops fetch after a zero word.
module imem_fetch_ctrl #(
  parameter int N     = 32,
  parameter int AW    = 7,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_q,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [N-1:0]  instr,
  output logic [63:0]   instr_pc,
  output logic [63:0]   fetch_pc_o
`ifdef FETCH_HALT_EN
  ,
  output logic          halted
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Architectural state
  logic [63:0]   r_fetch_pc;
  logic [N-1:0]  r_q_dat [DEPTH];
  logic [63:0]   r_q_pc  [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_instr_vld;
  logic [N-1:0]  r_instr;
  logic [63:0]   r_instr_pc;

  // Next-state helpers
  logic          w_halt_blk;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_cnt_after_pop;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic          w_bypass;
  logic [N-1:0]  w_head_dat;
  logic [63:0]   w_head_pc;
  logic [63:0]   w_redirect_tgt;

`ifdef FETCH_HALT_EN
  logic r_halted;

  // Halt latch: set when a zero word is enqueued, cleared by any redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_halted <= 1'b0;
    end else if (w_push && (imem_q == '0)) begin
      r_halted <= 1'b1;
    end
  end

  assign w_halt_blk = r_halted;
  assign halted     = r_halted;
`else
  assign w_halt_blk = 1'b0;
`endif

  // Handshake and queue-occupancy arithmetic
  always_comb begin
    w_pop           = r_instr_vld & instr_ready;
    w_push          = ~redirect_valid & ~w_halt_blk & ((r_count < FULL) | w_pop);
    w_cnt_after_pop = r_count - {{(CW-1){1'b0}}, w_pop};
    w_cnt_nxt       = redirect_valid ? '0 : (w_cnt_after_pop + {{(CW-1){1'b0}}, w_push});
    w_rd_nxt        = redirect_valid ? '0 : (r_rd_ptr + {{(PW-1){1'b0}}, w_pop});
    // The slot being written becomes the head only when the queue would otherwise be empty
    w_bypass        = w_push & (w_cnt_after_pop == '0);
    w_head_dat      = w_bypass ? imem_q     : r_q_dat[w_rd_nxt];
    w_head_pc       = w_bypass ? r_fetch_pc : r_q_pc[w_rd_nxt];
    w_redirect_tgt  = redirect_pc & ~64'h3;
  end

  // Queue storage: capture the addressed word together with its PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_dat[i] <= '0;
        r_q_pc[i]  <= '0;
      end
    end else if (w_push) begin
      r_q_dat[r_wr_ptr] <= imem_q;
      r_q_pc[r_wr_ptr]  <= r_fetch_pc;
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      if (redirect_valid) begin
        r_wr_ptr <= '0;
      end else if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Fetch PC: jump on redirect, advance by one word on every push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_tgt;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 64'd4;
    end
  end

  // Registered head: load the post-edge head, hold the last value while empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_vld <= 1'b0;
      r_instr     <= '0;
      r_instr_pc  <= '0;
    end else begin
      r_instr_vld <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) begin
        r_instr    <= w_head_dat;
        r_instr_pc <= w_head_pc;
      end
    end
  end

  assign imem_addr   = r_fetch_pc[AW+1:2];
  assign fetch_pc_o  = r_fetch_pc;
  assign instr_valid = r_instr_vld;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: fixed ROM image, hand-computed expected head/PC per cycle.
// Outputs are sampled and inputs driven on the falling clock edge.
// Build with FETCH_HALT_EN defined to also exercise the halted output.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [6:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic [63:0] fetch_pc_o;
`ifdef FETCH_HALT_EN
  logic        halted;
`endif

  logic [31:0] rom [128];
  int n_tests;
  int n_fail;

  assign imem_q = rom[imem_addr];

  imem_fetch_ctrl #(.N(32), .AW(7), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
`ifdef FETCH_HALT_EN
    .halted         (halted),
`endif
    .fetch_pc_o     (fetch_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [31:0] first3 [3];
    first3[0] = 32'hf800_0001;
    first3[1] = 32'hf800_8002;
    first3[2] = 32'hf800_0203;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 128; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0]  = first3[0];
    rom[1]  = first3[1];
    rom[2]  = first3[2];
    rom[47] = 32'h0;

    reset          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_pc", instr_pc, 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_fpc", fetch_pc_o, 64'd0);
`ifdef FETCH_HALT_EN
    check("rst_halted", 64'(halted), 64'd0);
`endif

    // Release with decode ready: one word per cycle, first one after the first edge
    reset       = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("seq_valid", 64'(instr_valid), 64'd1);
      check("seq_instr", 64'(instr), 64'(first3[k]));
      check("seq_pc", instr_pc, 64'(4 * k));
    end

    // Stall decode: queue fills (head 8, entries 8,C,10,14), fetch_pc parks at 0x18
    instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("full_fpc", fetch_pc_o, 64'h18);
    check("full_addr", 64'(imem_addr), 64'd6);
    check("full_head", instr_pc, 64'h8);

    // Asynchronous reset mid-cycle with a full queue
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 64'(instr_valid), 64'd0);
    check("arst_fpc", fetch_pc_o, 64'd0);
    check("arst_addr", 64'(imem_addr), 64'd0);

    // Restart from 0 with decode stalled: saturates at 4 entries, fetch_pc holds 0x10
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("sat_fpc", fetch_pc_o, 64'h10);
    check("sat_addr", 64'(imem_addr), 64'd4);
    check("sat_valid", 64'(instr_valid), 64'd1);
    check("sat_head", instr_pc, 64'h0);

    // Drain: 0,4,8,C,10 back to back
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_valid", 64'(instr_valid), 64'd1);
      check("drain_pc", instr_pc, 64'(4 * k));
      check("drain_instr", 64'(instr), 64'(rom[k]));
      if (k < 4) @(negedge clk);
    end

    // Redirect to 0x94 coinciding with a pop
    redirect_valid = 1'b1;
    redirect_pc    = 64'h94;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir_valid", 64'(instr_valid), 64'd0);
    check("redir_fpc", fetch_pc_o, 64'h94);
    check("redir_addr", 64'(imem_addr), 64'd37);
    check("redir_hold", instr_pc, 64'h10);
    @(negedge clk);
    check("tgt_valid", 64'(instr_valid), 64'd1);
    check("tgt_pc", instr_pc, 64'h94);
    check("tgt_instr", 64'(instr), 64'(rom[37]));
    @(negedge clk);
    check("tgt_next_pc", instr_pc, 64'h98);

    // Back-to-back redirects, last one (0x1FE) wins with low bits dropped
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    @(negedge clk);
    check("b2b_valid0", 64'(instr_valid), 64'd0);
    check("b2b_fpc0", fetch_pc_o, 64'h40);
    redirect_pc = 64'h1FE;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("b2b_valid1", 64'(instr_valid), 64'd0);
    check("b2b_fpc1", fetch_pc_o, 64'h1FC);
    check("b2b_addr", 64'(imem_addr), 64'd127);
    @(negedge clk);
    check("top_pc", instr_pc, 64'h1FC);
    check("top_instr", 64'(instr), 64'(rom[127]));
    check("alias_addr", 64'(imem_addr), 64'd0);
    check("alias_fpc", fetch_pc_o, 64'h200);
    @(negedge clk);
    check("alias_pc", instr_pc, 64'h200);
    check("alias_instr", 64'(instr), 64'(rom[0]));

    // Zero word at 0xBC
    redirect_valid = 1'b1;
    redirect_pc    = 64'hB8;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("z_redir_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    check("z_pre_pc", instr_pc, 64'hB8);
    check("z_pre_instr", 64'(instr), 64'(rom[46]));
`ifdef FETCH_HALT_EN
    check("z_pre_halted", 64'(halted), 64'd0);
`endif
    @(negedge clk);
    check("z_valid", 64'(instr_valid), 64'd1);
    check("z_pc", instr_pc, 64'hBC);
    check("z_instr", 64'(instr), 64'd0);
`ifdef FETCH_HALT_EN
    check("z_halted", 64'(halted), 64'd1);
    repeat (4) @(negedge clk);
    check("halt_valid", 64'(instr_valid), 64'd0);
    check("halt_fpc", fetch_pc_o, 64'hC0);
    check("halt_held", 64'(halted), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("unhalt", 64'(halted), 64'd0);
    check("unhalt_fpc", fetch_pc_o, 64'h0);
    @(negedge clk);
    check("resume_valid", 64'(instr_valid), 64'd1);
    check("resume_pc", instr_pc, 64'h0);
    check("resume_instr", 64'(instr), 64'(rom[0]));
`else
    @(negedge clk);
    check("post_z_valid", 64'(instr_valid), 64'd1);
    check("post_z_pc", instr_pc, 64'hC0);
    check("post_z_instr", 64'(instr), 64'(rom[48]));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
